// File: rtl/input_row_feeder_pkg.sv
// Shared definitions for the input row feeder: sizing constants, FSM state
// encoding, row/counter types and the row-count clamp helper.
package input_row_feeder_pkg;

  localparam int FULL_SIZE    = 8;
  localparam int DATA_WIDTH   = 16;
  localparam int DEPTH        = 32;
  localparam int DRAIN_CYCLES = 8;

  localparam int ROW_W   = FULL_SIZE * DATA_WIDTH;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_e;

  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [DRAIN_W-1:0] drain_cnt_t;

  // A tile never holds more rows than the buffer can store.
  function automatic cnt_t clamp_rows(input cnt_t requested);
    cnt_t limited;
    limited = (requested > cnt_t'(DEPTH)) ? cnt_t'(DEPTH) : requested;
    return limited;
  endfunction

endpackage

// File: rtl/input_row_feeder_if.sv
// Bus between the row producer/parser side and the feeder. The feeder takes
// the slave modport; whoever drives tiles and consumes rows takes master.
interface input_row_feeder_if;
  import input_row_feeder_pkg::*;

  logic start;
  cnt_t num_rows;
  logic tile_mode;
  logic wr_valid;
  logic wr_ready;
  row_t wr_data;
  logic out_enable;
  logic out_tile;
  row_t out_0;
  row_t out_1;
  logic busy;
  logic done;

  modport master (
    output start, num_rows, tile_mode, wr_valid, wr_data,
    input  wr_ready, out_enable, out_tile, out_0, out_1, busy, done
  );

  modport slave (
    input  start, num_rows, tile_mode, wr_valid, wr_data,
    output wr_ready, out_enable, out_tile, out_0, out_1, busy, done
  );

endinterface

// File: rtl/input_row_feeder_row_ram.sv
// Row buffer for one tile: one write port and two registered read ports.
// The read registers double as the feeder's data outputs, so they carry a
// reset and a zero-select; the storage array itself is never reset.
// A write to the address being read forwards the new row, which lets the
// last row of a tile be streamed out the cycle right after it lands.
module feeder_row_ram
  import input_row_feeder_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  row_t  wr_data,
  input  addr_t rd_addr_a,
  input  logic  rd_zero_a,
  input  addr_t rd_addr_b,
  input  logic  rd_zero_b,
  output row_t  rd_data_a,
  output row_t  rd_data_b
);

  row_t mem [DEPTH];

  // Row storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read ports with zero-select and write-through forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (rd_zero_a) begin
        rd_data_a <= '0;
      end else if (wr_en && (wr_addr == rd_addr_a)) begin
        rd_data_a <= wr_data;
      end else begin
        rd_data_a <= mem[rd_addr_a];
      end

      if (rd_zero_b) begin
        rd_data_b <= '0;
      end else if (wr_en && (wr_addr == rd_addr_b)) begin
        rd_data_b <= wr_data;
      end else begin
        rd_data_b <= mem[rd_addr_b];
      end
    end
  end

endmodule

// File: rtl/input_row_feeder.sv
// Input row feeder: buffers one tile of A-matrix rows, streams them into the
// input parser one or two rows per cycle, then feeds zero vectors so the
// parser's triangle shifters drain. Every output comes straight from a flop.
module input_row_feeder
  import input_row_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input_row_feeder_if.slave    bus
);

  feeder_state_e state, state_next;

  cnt_t       n_rows, n_next;
  logic       tile_q, tile_next;
  cnt_t       wr_cnt, wr_cnt_next;
  cnt_t       rd_cnt, rd_cnt_next;
  drain_cnt_t drain_cnt, drain_next;

  logic wr_ready_q, wr_ready_next;
  logic enable_q, enable_next;
  logic out_tile_q, out_tile_next;
  logic busy_q, busy_next;
  logic done_q, done_next;

  logic  wr_en;
  logic  issue;
  cnt_t  rd_base;
  cnt_t  rd_sum;
  addr_t rd_addr_a, rd_addr_b;
  logic  rd_zero_a, rd_zero_b;

  localparam drain_cnt_t DRAIN_LAST = drain_cnt_t'(DRAIN_CYCLES - 1);

  feeder_row_ram u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_cnt[ADDR_W-1:0]),
    .wr_data   (bus.wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_zero_a (rd_zero_a),
    .rd_addr_b (rd_addr_b),
    .rd_zero_b (rd_zero_b),
    .rd_data_a (bus.out_0),
    .rd_data_b (bus.out_1)
  );

  assign bus.wr_ready   = wr_ready_q;
  assign bus.out_enable = enable_q;
  assign bus.out_tile   = out_tile_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Next-state, counter and read-address logic; the read for a stream cycle
  // is issued on the edge that starts it, including the prefetch at LOAD exit.
  always_comb begin
    state_next  = state;
    n_next      = n_rows;
    tile_next   = tile_q;
    wr_cnt_next = wr_cnt;
    rd_cnt_next = rd_cnt;
    drain_next  = drain_cnt;
    issue       = 1'b0;
    rd_base     = '0;
    rd_sum      = '0;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    rd_zero_a   = 1'b1;
    rd_zero_b   = 1'b1;
    wr_en       = (state == ST_LOAD) && bus.wr_valid && wr_ready_q;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          n_next      = clamp_rows(bus.num_rows);
          tile_next   = bus.tile_mode;
          wr_cnt_next = '0;
          rd_cnt_next = '0;
          drain_next  = '0;
          state_next  = (n_next == '0) ? ST_DRAIN : ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (wr_en) begin
          wr_cnt_next = wr_cnt + cnt_t'(1);
          if (wr_cnt_next == n_rows) begin
            state_next = ST_STREAM;
            issue      = 1'b1;
            rd_base    = '0;
          end
        end
      end

      ST_STREAM: begin
        if (rd_cnt < n_rows) begin
          issue   = 1'b1;
          rd_base = rd_cnt;
        end else begin
          state_next = ST_DRAIN;
          drain_next = '0;
        end
      end

      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = ST_IDLE;
        end else begin
          drain_next = drain_cnt + drain_cnt_t'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (issue) begin
      rd_addr_a   = rd_base[ADDR_W-1:0];
      rd_zero_a   = 1'b0;
      rd_addr_b   = rd_base[ADDR_W-1:0] + addr_t'(1);
      rd_zero_b   = !(tile_q && ((rd_base + cnt_t'(1)) < n_rows));
      rd_sum      = rd_base + (tile_q ? cnt_t'(2) : cnt_t'(1));
      rd_cnt_next = (rd_sum > n_rows) ? n_rows : rd_sum;
    end

    wr_ready_next = (state_next == ST_LOAD);
    enable_next   = (state_next == ST_STREAM) || (state_next == ST_DRAIN);
    out_tile_next = enable_next && tile_next;
    busy_next     = (state_next != ST_IDLE);
    done_next     = (state_next == ST_DRAIN) && (drain_next == DRAIN_LAST);
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      n_rows     <= '0;
      tile_q     <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      drain_cnt  <= '0;
      wr_ready_q <= 1'b0;
      enable_q   <= 1'b0;
      out_tile_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      n_rows     <= n_next;
      tile_q     <= tile_next;
      wr_cnt     <= wr_cnt_next;
      rd_cnt     <= rd_cnt_next;
      drain_cnt  <= drain_next;
      wr_ready_q <= wr_ready_next;
      enable_q   <= enable_next;
      out_tile_q <= out_tile_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
    end
  end

endmodule

// File: tb/tb_input_row_feeder.sv
// Testbench for input_row_feeder: a table of tiles applied back to back,
// plus hand-written reset sequences around them.
module tb_input_row_feeder;
  import input_row_feeder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  input_row_feeder_if bus();

  input_row_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int num_rows;
    bit tile_mode;
    int exp_n;
    int exp_cycles;
    bit backpressure;
    bit poke_start;
  } vec_t;

  vec_t vecs [10];
  int vec_count  = 0;
  int miss_count = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t splat(input int tag, input int idx);
    logic [DATA_WIDTH-1:0] v;
    row_t r;
    v = DATA_WIDTH'(tag * 256 + idx + 1);
    for (int e = 0; e < FULL_SIZE; e++) begin
      r[e*DATA_WIDTH +: DATA_WIDTH] = v;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input row_t act, input row_t exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    row_t e0, e1;
    checkOutput("idle_busy", row_t'(bus.busy), row_t'(0));
    bus.start     = 1'b1;
    bus.num_rows  = CNT_W'(v.num_rows);
    bus.tile_mode = v.tile_mode;
    tick();
    bus.start     = 1'b0;
    bus.num_rows  = '0;
    bus.tile_mode = 1'b0;
    checkOutput("busy_after_start", row_t'(bus.busy), row_t'(1));
    checkOutput("enable_after_start", row_t'(bus.out_enable), row_t'(v.exp_n == 0));

    for (int i = 0; i < v.exp_n; i++) begin
      if (v.backpressure) begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = splat(99, i);
        tick();
      end
      checkOutput("wr_ready_in_load", row_t'(bus.wr_ready), row_t'(1));
      if (v.poke_start && i == 1) begin
        bus.start     = 1'b1;
        bus.num_rows  = CNT_W'(2);
        bus.tile_mode = ~v.tile_mode;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = splat(tag, i);
      tick();
      bus.start     = 1'b0;
      bus.num_rows  = '0;
      bus.tile_mode = 1'b0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = splat(77, i);
    end
    if (v.exp_n > 0) begin
      checkOutput("wr_ready_after_load", row_t'(bus.wr_ready), row_t'(0));
    end

    for (int k = 0; k < v.exp_cycles; k++) begin
      if (v.tile_mode) begin
        e0 = splat(tag, 2 * k);
        e1 = (2 * k + 1 < v.exp_n) ? splat(tag, 2 * k + 1) : '0;
      end else begin
        e0 = splat(tag, k);
        e1 = '0;
      end
      checkOutput("stream_out_0", bus.out_0, e0);
      checkOutput("stream_out_1", bus.out_1, e1);
      checkOutput("stream_enable", row_t'(bus.out_enable), row_t'(1));
      checkOutput("stream_tile", row_t'(bus.out_tile), row_t'(v.tile_mode));
      checkOutput("stream_done", row_t'(bus.done), row_t'(0));
      if (v.poke_start && k == 0) begin
        bus.start    = 1'b1;
        bus.num_rows = CNT_W'(1);
        bus.wr_valid = 1'b1;
      end
      tick();
      bus.start    = 1'b0;
      bus.num_rows = '0;
      bus.wr_valid = 1'b0;
    end

    for (int d = 0; d < DRAIN_CYCLES; d++) begin
      checkOutput("drain_out_0", bus.out_0, '0);
      checkOutput("drain_out_1", bus.out_1, '0);
      checkOutput("drain_enable", row_t'(bus.out_enable), row_t'(1));
      checkOutput("drain_tile", row_t'(bus.out_tile), row_t'(v.tile_mode));
      checkOutput("drain_done", row_t'(bus.done), row_t'(d == DRAIN_CYCLES - 1));
      tick();
    end

    checkOutput("post_busy", row_t'(bus.busy), row_t'(0));
    checkOutput("post_done", row_t'(bus.done), row_t'(0));
    checkOutput("post_enable", row_t'(bus.out_enable), row_t'(0));
    checkOutput("post_tile", row_t'(bus.out_tile), row_t'(0));
  endtask

  initial begin
    vecs[0] = '{4,  1'b0, 4,  4,  1'b0, 1'b0};
    vecs[1] = '{5,  1'b1, 5,  3,  1'b0, 1'b0};
    vecs[2] = '{3,  1'b0, 3,  3,  1'b1, 1'b0};
    vecs[3] = '{0,  1'b0, 0,  0,  1'b0, 1'b0};
    vecs[4] = '{40, 1'b0, 32, 32, 1'b0, 1'b0};
    vecs[5] = '{6,  1'b1, 6,  3,  1'b0, 1'b1};
    vecs[6] = '{1,  1'b0, 1,  1,  1'b0, 1'b0};
    vecs[7] = '{1,  1'b1, 1,  1,  1'b0, 1'b0};
    vecs[8] = '{2,  1'b1, 2,  1,  1'b0, 1'b0};
    vecs[9] = '{32, 1'b1, 32, 16, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.num_rows  = '0;
    bus.tile_mode = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    repeat (3) tick();
    checkOutput("reset_busy", row_t'(bus.busy), row_t'(0));
    checkOutput("reset_wr_ready", row_t'(bus.wr_ready), row_t'(0));
    checkOutput("reset_enable", row_t'(bus.out_enable), row_t'(0));
    checkOutput("reset_done", row_t'(bus.done), row_t'(0));
    checkOutput("reset_out_0", bus.out_0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Partial tile interrupted by reset in the middle of STREAM.
    bus.start    = 1'b1;
    bus.num_rows = CNT_W'(4);
    tick();
    bus.start    = 1'b0;
    bus.num_rows = '0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = splat(15, i);
      tick();
    end
    bus.wr_valid = 1'b0;
    checkOutput("pre_reset_stream", bus.out_0, splat(15, 0));
    tick();
    checkOutput("pre_reset_stream_row1", bus.out_0, splat(15, 1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_0", bus.out_0, '0);
    checkOutput("midreset_busy", row_t'(bus.busy), row_t'(0));
    checkOutput("midreset_enable", row_t'(bus.out_enable), row_t'(0));
    checkOutput("midreset_done", row_t'(bus.done), row_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 10; t++) begin
      applyStimulus(vecs[t], t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
